// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage and a debug/boot-load port.
// Optional: define DMEM_ARB_PERF_EN to add the cpu-stall and debug-grant performance counters.
module dmem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_halt_req,
    output logic              dbg_gnt,
    output logic              dbg_halted,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              perf_clr,
    output logic [31:0]       perf_cpu_stall_cnt,
    output logic [31:0]       perf_dbg_gnt_cnt
);
    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;
    typedef enum logic [1:0] {NONE, CPU, DBG} owner_t;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    state_t state, state_nx;
    owner_t owner, rd_owner;
    logic [7:0] starve_cnt;
    logic [DATA_W-1:0] cpu_hold, dbg_hold;
    logic cpu_sel, dbg_sel;
    // Owner selection and next state; nothing owns the memory while reset is held
    always_comb begin
        owner = NONE;
        state_nx = RUN;
        unique case (state)
            RUN: begin
                owner = (dbg_req && starve_cnt == LIMIT) ? DBG : cpu_req ? CPU : dbg_req ? DBG : NONE;
                state_nx = dbg_halt_req ? (cpu_req ? HALT_PEND : HALTED) : RUN;
            end
            HALT_PEND: begin
                owner = cpu_req ? CPU : dbg_req ? DBG : NONE;
                state_nx = dbg_halt_req ? HALTED : RUN;
            end
            HALTED: begin
                owner = dbg_req ? DBG : NONE;
                state_nx = dbg_halt_req ? HALTED : RUN;
            end
            default: state_nx = RUN;
        endcase
        if (!reset_n) owner = NONE;
    end
    assign cpu_sel    = owner == CPU;
    assign dbg_sel    = owner == DBG;
    assign mem_addr   = cpu_sel ? cpu_addr : dbg_sel ? dbg_addr : '0;
    assign mem_wdata  = cpu_sel ? cpu_wdata : dbg_sel ? dbg_wdata : '0;
    assign mem_rden   = cpu_sel ? ~cpu_we : dbg_sel & ~dbg_we;
    assign mem_wren   = cpu_sel ? cpu_we : dbg_sel & dbg_we;
    assign cpu_stall  = reset_n & cpu_req & ~cpu_sel;
    assign dbg_gnt    = dbg_sel;
    assign dbg_halted = state == HALTED;
    assign dbg_rvalid = rd_owner == DBG;
    assign cpu_rdata  = rd_owner == CPU ? mem_q : cpu_hold;
    assign dbg_rdata  = dbg_rvalid ? mem_q : dbg_hold;
    // State register, starvation counter and read-return owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            starve_cnt <= '0;
            rd_owner   <= NONE;
        end else begin
            state      <= state_nx;
            starve_cnt <= (dbg_req && !dbg_gnt) ? (starve_cnt == LIMIT ? starve_cnt : starve_cnt + 8'd1) : '0;
            rd_owner   <= mem_rden ? owner : NONE;
        end
    end
    // Capture returned read data so each requester's data holds until its next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_hold <= '0;
            dbg_hold <= '0;
        end else begin
            if (rd_owner == CPU) cpu_hold <= mem_q;
            if (rd_owner == DBG) dbg_hold <= mem_q;
        end
    end
`ifdef DMEM_ARB_PERF_EN
    // Saturating counters of CPU stall cycles and debug grants
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cpu_stall_cnt <= '0;
            perf_dbg_gnt_cnt   <= '0;
        end else if (perf_clr) begin
            perf_cpu_stall_cnt <= '0;
            perf_dbg_gnt_cnt   <= '0;
        end else begin
            if (cpu_stall && perf_cpu_stall_cnt != '1) perf_cpu_stall_cnt <= perf_cpu_stall_cnt + 32'd1;
            if (dbg_gnt && perf_dbg_gnt_cnt != '1) perf_dbg_gnt_cnt <= perf_dbg_gnt_cnt + 32'd1;
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr    = perf_clr;
    assign perf_cpu_stall_cnt = '0;
    assign perf_dbg_gnt_cnt   = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter against a rule-level reference model.
module tb_dmem_arbiter;
    localparam int LIM = 8;
    logic clk = 0, reset_n = 0;
    logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_halt_req = 0, perf_clr = 0;
    logic [4:0] cpu_addr = 0, dbg_addr = 0;
    logic [63:0] cpu_wdata = 0, dbg_wdata = 0;
    logic cpu_stall, dbg_gnt, dbg_halted, dbg_rvalid, mem_rden, mem_wren;
    logic [4:0] mem_addr;
    logic [63:0] cpu_rdata, dbg_rdata, mem_wdata, mem_q;
    logic [31:0] perf_cpu_stall_cnt, perf_dbg_gnt_cnt;
    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_halt_req(dbg_halt_req), .dbg_gnt(dbg_gnt), .dbg_halted(dbg_halted),
        .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_q(mem_q), .perf_clr(perf_clr),
        .perf_cpu_stall_cnt(perf_cpu_stall_cnt), .perf_dbg_gnt_cnt(perf_dbg_gnt_cnt)
    );

    // Single-port memory with registered read, preloaded from the shadow image
    logic [63:0] mem [32];
    logic [63:0] shadow [32];
    logic do_load = 0;
    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= shadow[i];
        end else begin
            if (mem_wren) mem[mem_addr] <= mem_wdata;
            if (mem_rden) mem_q <= mem[mem_addr];
        end
    end

    typedef struct {
        logic stall, gnt, halted, rden, wren, rvalid;
        logic [4:0] addr;
        logic [63:0] wdata, cpu_rd, dbg_rd;
        logic [31:0] pcs, pdg;
    } exp_t;

    int n_cmp = 0, n_bad = 0;
    exp_t q [$];
    logic [63:0] dbg_rd_q [$];
    bit mon_on = 0;
    exp_t e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compares each cycle's outputs and every debug read return against the scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            if (dbg_rvalid) begin
                if (dbg_rd_q.size() == 0) chk("dbg_unexpected_rvalid", 1, 0);
                else chk("dbg_read_return", dbg_rdata, dbg_rd_q.pop_front());
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("cpu_stall", cpu_stall, e.stall);
                chk("dbg_gnt", dbg_gnt, e.gnt);
                chk("dbg_halted", dbg_halted, e.halted);
                chk("mem_rden", mem_rden, e.rden);
                chk("mem_wren", mem_wren, e.wren);
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_wdata", mem_wdata, e.wdata);
                chk("dbg_rvalid", dbg_rvalid, e.rvalid);
                chk("cpu_rdata", cpu_rdata, e.cpu_rd);
                chk("dbg_rdata", dbg_rdata, e.dbg_rd);
                chk("perf_cpu_stall_cnt", perf_cpu_stall_cnt, e.pcs);
                chk("perf_dbg_gnt_cnt", perf_dbg_gnt_cnt, e.pdg);
            end
        end
    end

    initial begin
        int pc_t [4] = '{50, 100, 70, 20};
        int pd_t [4] = '{30, 100, 40, 80};
        bit ph_t [4] = '{0, 0, 1, 1};
        bit halted = 0, pend = 0, cpu_ret = 0, dbg_ret = 0, prev_stall = 0, prev_dpend = 0, we;
        int wcnt = 0, own;
        logic [4:0] a;
        logic [63:0] d, cpu_ret_v = 0, dbg_ret_v = 0, cpu_hold = 0, dbg_hold = 0;
        logic [31:0] pcs = 0, pdg = 0;
        exp_t x;
        for (int i = 0; i < 32; i++) shadow[i] = {$urandom(), $urandom()};
        shadow[5] = 64'hDEAD;
        shadow[3] = 64'h3333_0000_3333;
        // Reset with requests active: every output must stay 0
        do_load = 1;
        cpu_req = 1; dbg_req = 1; dbg_halt_req = 1; dbg_we = 1; dbg_addr = 5'd9;
        @(negedge clk); @(negedge clk);
        do_load = 0;
        chk("reset_cpu_stall", cpu_stall, 0);
        chk("reset_dbg_gnt", dbg_gnt, 0);
        chk("reset_dbg_halted", dbg_halted, 0);
        chk("reset_mem_en", {mem_rden, mem_wren}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_dbg_rvalid", dbg_rvalid, 0);
        chk("reset_cpu_rdata", cpu_rdata, 0);
        // CPU load of address 3 granted, then reset hits during the return cycle
        dbg_req = 0; dbg_halt_req = 0; dbg_we = 0; dbg_addr = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
        reset_n = 1;
        #1;
        chk("midrd_grant_rden", mem_rden, 1);
        chk("midrd_grant_addr", mem_addr, 3);
        chk("midrd_grant_stall", cpu_stall, 0);
        @(posedge clk); #1;
        reset_n = 0;
        #1;
        chk("midrd_cpu_rdata", cpu_rdata, 0);
        chk("midrd_dbg_rvalid", dbg_rvalid, 0);
        cpu_req = 0; cpu_addr = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("midrd_after_cpu_rdata", cpu_rdata, 0);
        chk("midrd_after_dbg_halted", dbg_halted, 0);
        // Randomized phases: light load, saturated load (starvation), halt traffic
        mon_on = 1;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 400; c++) begin
                @(posedge clk); #1;
                if (!(cpu_req && prev_stall)) begin
                    cpu_req = $urandom_range(99) < pc_t[p];
                    cpu_we = 1'($urandom_range(1));
                    cpu_addr = 5'($urandom);
                    cpu_wdata = {$urandom(), $urandom()};
                end
                if (!prev_dpend) begin
                    dbg_req = $urandom_range(99) < pd_t[p];
                    dbg_we = 1'($urandom_range(1));
                    dbg_addr = 5'($urandom);
                    dbg_wdata = {$urandom(), $urandom()};
                end
                if (!ph_t[p]) dbg_halt_req = 0;
                else if ($urandom_range(99) < 4) dbg_halt_req = ~dbg_halt_req;
                perf_clr = $urandom_range(99) < 2;
                // Who wins this cycle, from the arbitration rules
                if (halted) own = dbg_req ? 2 : 0;
                else if (pend) own = cpu_req ? 1 : dbg_req ? 2 : 0;
                else if (dbg_req && wcnt == LIM) own = 2;
                else own = cpu_req ? 1 : dbg_req ? 2 : 0;
                we = own == 1 ? cpu_we : dbg_we;
                a = own == 1 ? cpu_addr : dbg_addr;
                d = own == 1 ? cpu_wdata : dbg_wdata;
                x.stall = cpu_req && own != 1;
                x.gnt = own == 2;
                x.halted = halted;
                x.rden = own != 0 && !we;
                x.wren = own != 0 && we;
                x.addr = own != 0 ? a : 5'd0;
                x.wdata = own != 0 ? d : 64'd0;
                x.rvalid = dbg_ret;
                x.cpu_rd = cpu_ret ? cpu_ret_v : cpu_hold;
                x.dbg_rd = dbg_ret ? dbg_ret_v : dbg_hold;
`ifdef DMEM_ARB_PERF_EN
                x.pcs = pcs; x.pdg = pdg;
`else
                x.pcs = 0; x.pdg = 0;
`endif
                q.push_back(x);
                if (cpu_ret) cpu_hold = cpu_ret_v;
                if (dbg_ret) dbg_hold = dbg_ret_v;
                cpu_ret = own == 1 && !we;
                dbg_ret = own == 2 && !we;
                if (cpu_ret) cpu_ret_v = shadow[a];
                if (dbg_ret) begin
                    dbg_ret_v = shadow[a];
                    dbg_rd_q.push_back(shadow[a]);
                end
                if (own != 0 && we) shadow[a] = d;
                wcnt = (dbg_req && own != 2) ? (wcnt < LIM ? wcnt + 1 : LIM) : 0;
                if (halted) halted = dbg_halt_req;
                else if (pend) begin
                    pend = 0;
                    halted = dbg_halt_req;
                end else if (dbg_halt_req) begin
                    if (cpu_req) pend = 1;
                    else halted = 1;
                end
                pcs = perf_clr ? 0 : pcs + 32'(x.stall);
                pdg = perf_clr ? 0 : pdg + 32'(x.gnt);
                prev_stall = x.stall;
                prev_dpend = dbg_req && own != 2;
            end
        end
        @(posedge clk); #1;
        cpu_req = 0; dbg_req = 0; dbg_halt_req = 0; perf_clr = 0;
        repeat (3) @(negedge clk);
        mon_on = 0;
        chk("dbg_reads_all_returned", 64'(dbg_rd_q.size()), 0);
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
